// File: rtl/morse_pkg.sv
// Shared definitions for the Morse TX scheduler slice.
// Contents: default ROM addresses for space/CR/LF, the scheduler FSM state
// encoding, and the bit positions of the fields inside sym_addr.
package morse_pkg;

  localparam int unsigned ADDR_W = 8;

  localparam logic [ADDR_W-1:0] SPACE_ADDR_DFLT = 8'hE0;
  localparam logic [ADDR_W-1:0] CR_ADDR_DFLT    = 8'hE1;
  localparam logic [ADDR_W-1:0] LF_ADDR_DFLT    = 8'hE2;

  // sym_addr = {symbol_count[2:0], symbol[4:0]}
  localparam int unsigned SYM_CNT_MSB = 7;
  localparam int unsigned SYM_CNT_LSB = 5;
  localparam int unsigned SYM_MSB     = 4;
  localparam int unsigned SYM_LSB     = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_WRITE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sched_queue.sv
// sched_queue: DEPTH x ADDR_W register queue for pending ROM addresses.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   i_push_n      - number of entries pushed this cycle (0..NPUSH)
//   i_push_data   - entries to push, index 0 goes in first
//   i_pop         - drop the head entry
//   o_head        - current head entry (only meaningful when o_count != 0)
//   o_count       - occupancy, one bit wider than the pointers
//   o_free        - DEPTH - o_count, evaluated before any same-cycle pop
// The caller must never push more than o_free nor pop when empty.
module sched_queue
  import morse_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned NPUSH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNTW  = AW + 1,
  localparam int unsigned CW    = $clog2(NPUSH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CW-1:0]                i_push_n,
  input  logic [NPUSH-1:0][ADDR_W-1:0] i_push_data,
  input  logic                         i_pop,
  output logic [ADDR_W-1:0]            o_head,
  output logic [CNTW-1:0]              o_count,
  output logic [CNTW-1:0]              o_free
);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CNTW-1:0]   r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NPUSH; i++) begin
        if (i < 32'(i_push_n)) r_mem[r_wr + AW'(i)] <= i_push_data[i];
      end
      r_wr  <= r_wr + AW'(i_push_n);
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CNTW'(i_push_n) - CNTW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_free  = CNTW'(DEPTH) - r_cnt;

endmodule

// File: rtl/morse_tx_scheduler.sv
// morse_tx_scheduler: queues ROM addresses implied by letter-gap, word-gap
// and newline events, performs the one-cycle-latency ROM lookup and writes
// each looked-up byte to the UART exactly once, honouring tx_full.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   lg, wg      - letter-gap / word-gap pulses; sym_addr valid with them
//   nl_req      - newline request pulse (pushes CR then LF)
//   rom_addr    - combinational queue head to the ROM, 8'h00 when empty
//   rom_data    - ROM output, valid one cycle after rom_addr
//   tx_full     - UART TX FIFO full
//   wr_uart     - one-cycle write strobe, w_data is the registered byte
//   busy        - queue non-empty or FSM not idle
//   overflow    - sticky, an event was dropped for lack of space
// Build option: define MORSE_TX_NEWLINE_EN to compile in the nl_req path;
// otherwise nl_req is ignored and CR_ADDR/LF_ADDR are unused.
module morse_tx_scheduler
  import morse_pkg::*;
#(
  parameter int unsigned       QDEPTH     = 4,
  parameter logic [ADDR_W-1:0] SPACE_ADDR = SPACE_ADDR_DFLT,
  parameter logic [ADDR_W-1:0] CR_ADDR    = CR_ADDR_DFLT,
  parameter logic [ADDR_W-1:0] LF_ADDR    = LF_ADDR_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lg,
  input  logic              wg,
  input  logic              nl_req,
  input  logic [ADDR_W-1:0] sym_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ADDR_W-1:0] rom_data,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [ADDR_W-1:0] w_data,
  output logic              busy,
  output logic              overflow
);

  // A decoder event plus a newline can land four entries in one cycle.
`ifdef MORSE_TX_NEWLINE_EN
  localparam int unsigned NPUSH = 4;
`else
  localparam int unsigned NPUSH = 2;
`endif
  localparam int unsigned AW   = $clog2(QDEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(NPUSH + 1);

  tx_state_t                  r_state, w_state_next;
  logic [ADDR_W-1:0]          r_w_data;
  logic                       r_overflow;

  logic                       w_has_cnt;
  int unsigned                w_dec_n;
  logic [ADDR_W-1:0]          w_d0, w_d1;
  logic [NPUSH-1:0][ADDR_W-1:0] w_push_data;
  int unsigned                w_k;
  logic [CW-1:0]              w_push_n;
  logic                       w_evt_drop;
  logic                       w_pop;
  logic                       w_wr;
  logic                       w_cap;
  int unsigned                w_occ_next;
  logic [ADDR_W-1:0]          w_head;
  logic [CNTW-1:0]            w_count;
  logic [CNTW-1:0]            w_free;

`ifndef MORSE_TX_NEWLINE_EN
  logic w_unused_nl;
  assign w_unused_nl = &{1'b0, nl_req, CR_ADDR, LF_ADDR};
`endif

  assign w_has_cnt = |sym_addr[SYM_CNT_MSB:SYM_CNT_LSB];

  // Decoder event: wg dominates lg; a zero symbol count yields no symbol entry.
  always_comb begin
    w_dec_n = 0;
    w_d0    = sym_addr;
    w_d1    = SPACE_ADDR;
    if (wg) begin
      if (w_has_cnt) begin
        w_dec_n = 2;
      end else begin
        w_dec_n = 1;
        w_d0    = SPACE_ADDR;
      end
    end else if (lg && w_has_cnt) begin
      w_dec_n = 1;
    end
  end

  // All-or-nothing admission against the pre-pop free count; the newline
  // only sees what the decoder event left behind.
  always_comb begin
    w_push_data = '0;
    w_k         = 0;
    w_evt_drop  = 1'b0;
    if (w_dec_n != 0) begin
      if (w_dec_n <= 32'(w_free)) begin
        w_push_data[0] = w_d0;
        w_push_data[1] = w_d1;
        w_k            = w_dec_n;
      end else begin
        w_evt_drop = 1'b1;
      end
    end
`ifdef MORSE_TX_NEWLINE_EN
    if (nl_req) begin
      if (32'(w_free) - w_k >= 2) begin
        case (w_k)
          0: begin w_push_data[0] = CR_ADDR; w_push_data[1] = LF_ADDR; end
          1: begin w_push_data[1] = CR_ADDR; w_push_data[2] = LF_ADDR; end
          default: begin w_push_data[2] = CR_ADDR; w_push_data[3] = LF_ADDR; end
        endcase
        w_k = w_k + 2;
      end else begin
        w_evt_drop = 1'b1;
      end
    end
`endif
  end

  assign w_push_n   = CW'(w_k);
  assign w_pop      = (r_state == ST_WRITE) && !tx_full;
  assign w_occ_next = 32'(w_count) + w_k - (w_pop ? 32'd1 : 32'd0);

  sched_queue #(
    .DEPTH (QDEPTH),
    .NPUSH (NPUSH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .i_push_n    (w_push_n),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_free      (w_free)
  );

  // Next-state looks at post-push occupancy so a fresh event reaches ADDR
  // in the following cycle without an extra IDLE bubble.
  always_comb begin
    w_state_next = r_state;
    w_wr         = 1'b0;
    w_cap        = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_occ_next != 0) w_state_next = ST_ADDR;
      ST_ADDR:  w_state_next = ST_DATA;
      ST_DATA:  begin
        w_cap        = 1'b1;
        w_state_next = ST_WRITE;
      end
      ST_WRITE: if (!tx_full) begin
        w_wr         = 1'b1;
        w_state_next = (w_occ_next != 0) ? ST_ADDR : ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_w_data   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_cap)      r_w_data   <= rom_data;
      if (w_evt_drop) r_overflow <= 1'b1;
    end
  end

  assign rom_addr = (w_count != '0) ? w_head : '0;
  assign wr_uart  = w_wr;
  assign w_data   = r_w_data;
  assign busy     = (w_count != '0) || (r_state != ST_IDLE);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
module tb_morse_tx_scheduler;

  localparam int          DEPTH = 4;
  localparam logic [7:0]  SP    = 8'hE0;
  localparam logic [7:0]  CRA   = 8'hE1;
  localparam logic [7:0]  LFA   = 8'hE2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lg = 1'b0, wg = 1'b0, nl_req = 1'b0, tx_full = 1'b0;
  logic [7:0] sym_addr = 8'h00;
  logic [7:0] rom_addr, rom_data, w_data;
  logic       wr_uart, busy, overflow;

  morse_tx_scheduler #(
    .QDEPTH     (DEPTH),
    .SPACE_ADDR (SP),
    .CR_ADDR    (CRA),
    .LF_ADDR    (LFA)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .lg       (lg),
    .wg       (wg),
    .nl_req   (nl_req),
    .sym_addr (sym_addr),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data = ~addr, one cycle latency.
  always @(posedge clk) rom_data <= ~rom_addr;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t_ev   = 0;

  task automatic cmp(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", n, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask

  // Reference model: queue of pending addresses with the cycle they were
  // accepted. A head entry becomes writable three cycles after the later of
  // its acceptance and the previous write, and is written on the first such
  // cycle with tx_full low.
  typedef struct { logic [7:0] a; int t; } ent_t;
  ent_t       mq[$];
  int         last_w  = -1000;
  logic [7:0] m_wdata = 8'h00;
  bit         m_ovf   = 1'b0;

  logic [7:0] wlog[$];
  int         wcy[$];

  int         er, fr;
  bit         pw;
  logic [7:0] ewd, era;
  logic [7:0] lst[$];

  always @(negedge clk) begin
    er  = (mq.size() > 0) ? (((mq[0].t > last_w) ? mq[0].t : last_w) + 3) : 0;
    pw  = (mq.size() > 0) && (cyc >= er) && !tx_full;
    ewd = ((mq.size() > 0) && (cyc >= er)) ? ~mq[0].a : m_wdata;
    era = (mq.size() > 0) ? mq[0].a : 8'h00;
    cmp("wr_uart",  {7'b0, wr_uart},  {7'b0, pw});
    cmp("w_data",   w_data,   ewd);
    cmp("rom_addr", rom_addr, era);
    cmp("busy",     {7'b0, busy},     {7'b0, (mq.size() > 0)});
    cmp("overflow", {7'b0, overflow}, {7'b0, m_ovf});
    if (wr_uart === 1'b1) begin
      wlog.push_back(w_data);
      wcy.push_back(cyc);
    end
    if (reset) begin
      mq.delete();
      last_w  = -1000;
      m_wdata = 8'h00;
      m_ovf   = 1'b0;
    end else begin
      fr = DEPTH - mq.size();
      if (pw) begin
        m_wdata = ~mq[0].a;
        last_w  = cyc;
        void'(mq.pop_front());
      end
      lst.delete();
      if (wg) begin
        if (sym_addr[7:5] != 3'b000) lst.push_back(sym_addr);
        lst.push_back(SP);
      end else if (lg && sym_addr[7:5] != 3'b000) begin
        lst.push_back(sym_addr);
      end
      if (lst.size() > 0) begin
        if (lst.size() <= fr) begin
          foreach (lst[i]) mq.push_back('{a: lst[i], t: cyc});
          fr = fr - lst.size();
        end else begin
          m_ovf = 1'b1;
        end
      end
`ifdef MORSE_TX_NEWLINE_EN
      if (nl_req) begin
        if (fr >= 2) begin
          mq.push_back('{a: CRA, t: cyc});
          mq.push_back('{a: LFA, t: cyc});
        end else begin
          m_ovf = 1'b1;
        end
      end
`endif
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic ev(input bit l, input bit w, input bit n, input logic [7:0] s);
    lg = l; wg = w; nl_req = n; sym_addr = s;
    t_ev = cyc;
    tick();
    lg = 1'b0; wg = 1'b0; nl_req = 1'b0;
  endtask

  task automatic clear_log();
    wlog.delete();
    wcy.delete();
  endtask

  logic [7:0] exp_b[$];
  int         t0;
  logic [7:0] s;

  initial begin
    tick(); tick();
    reset = 1'b0;
    idle(2);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_wdata", int'(w_data), 0);
    chk_int("reset_romaddr", int'(rom_addr), 0);

    // Single letter.
    clear_log();
    ev(1, 0, 0, 8'h42);
    t0 = t_ev;
    idle(7);
    chk_int("lg_count", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk_int("lg_data", int'(wlog[0]), 'hBD);
      chk_int("lg_latency", wcy[0] - t0, 3);
    end
    chk_int("lg_busy_after", int'(busy), 0);

    // Word gap with and without a symbol.
    clear_log();
    ev(0, 1, 0, 8'h61);
    t0 = t_ev;
    idle(10);
    chk_int("wg_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk_int("wg_b0", int'(wlog[0]), 'h9E);
      chk_int("wg_b1", int'(wlog[1]), 'h1F);
      chk_int("wg_gap", wcy[1] - wcy[0], 3);
      chk_int("wg_latency", wcy[0] - t0, 3);
    end
    clear_log();
    ev(0, 1, 0, 8'h00);
    idle(8);
    chk_int("wg0_count", wlog.size(), 1);
    if (wlog.size() == 1) chk_int("wg0_b0", int'(wlog[0]), 'h1F);

    // tx_full held through ten WRITE cycles.
    clear_log();
    ev(1, 0, 0, 8'h42);
    t0 = t_ev;
    tx_full = 1'b1;
    idle(12);
    chk_int("stall_nowrite", wlog.size(), 0);
    chk_int("stall_wdata", int'(w_data), 'hBD);
    tx_full = 1'b0;
    idle(4);
    chk_int("stall_count", wlog.size(), 1);
    if (wlog.size() == 1) chk_int("stall_release", wcy[0] - t0, 13);

    // Word gap and newline together.
    clear_log();
    ev(0, 1, 1, 8'h61);
    idle(16);
`ifdef MORSE_TX_NEWLINE_EN
    exp_b = '{8'h9E, 8'h1F, 8'h1E, 8'h1D};
`else
    exp_b = '{8'h9E, 8'h1F};
`endif
    chk_int("combo_count", wlog.size(), exp_b.size());
    if (wlog.size() == exp_b.size())
      foreach (exp_b[i]) chk_int("combo_byte", int'(wlog[i]), int'(exp_b[i]));

    // Three entries queued, then an event that cannot fit.
    clear_log();
    tx_full = 1'b1;
    ev(1, 0, 0, 8'h21);
    ev(1, 0, 0, 8'h21);
    ev(1, 0, 0, 8'h21);
    ev(0, 1, 1, 8'h61);
    chk_int("ovf_set", int'(overflow), 1);
    tx_full = 1'b0;
    idle(15);
    chk_int("ovf_count", wlog.size(), 3);
    if (wlog.size() == 3)
      foreach (wlog[i]) chk_int("ovf_byte", int'(wlog[i]), 'hDE);
    chk_int("ovf_sticky", int'(overflow), 1);

    // Reset mid-stream.
    clear_log();
    tx_full = 1'b1;
    ev(1, 0, 0, 8'h21);
    ev(1, 0, 0, 8'h22);
    ev(1, 0, 0, 8'h23);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tx_full = 1'b0;
    chk_int("rst_busy", int'(busy), 0);
    chk_int("rst_ovf", int'(overflow), 0);
    idle(8);
    chk_int("rst_nowrite", wlog.size(), 0);

    // Newline alone.
    clear_log();
    ev(0, 0, 1, 8'h00);
    idle(8);
`ifdef MORSE_TX_NEWLINE_EN
    chk_int("nl_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk_int("nl_cr", int'(wlog[0]), 'h1E);
      chk_int("nl_lf", int'(wlog[1]), 'h1D);
    end
`else
    chk_int("nl_count", wlog.size(), 0);
    chk_int("nl_busy", int'(busy), 0);
`endif

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      s = 8'($urandom);
      if ($urandom_range(3) == 0) s[7:5] = 3'b000;
      sym_addr = s;
      lg       = ($urandom_range(5) == 0);
      wg       = ($urandom_range(9) == 0);
      nl_req   = ($urandom_range(11) == 0);
      if ($urandom_range(7) == 0) tx_full = ~tx_full;
      reset    = ($urandom_range(399) == 0);
      tick();
    end
    lg = 1'b0; wg = 1'b0; nl_req = 1'b0; reset = 1'b0; tx_full = 1'b0;
    idle(20);
    chk_int("drain_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
